// File: rtl/pc_redirect.sv
// pc_redirect -- fetch program-counter sequencer with ID-stage redirect.
//
// Issues sequential fetch requests (pc, pc+4, ...) to instruction memory.
// Taken branches, JAL and JALR resolved in ID redirect the fetch stream.
// A redirect that arrives while a fetch request is still waiting for
// ready parks the target in pend_pc. The old request then completes,
// and the response that belongs to it is killed.
//
// Optional feature macro: REDIRECT_CNT_EN
//   defined   -> 32-bit saturating redirect_cnt / fetch_cnt counters
//   undefined -> counter ports tied to zero, no counter flops
module pc_redirect #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [63:0] id_pc,
    input  logic [63:0] id_imm,
    input  logic        br_taken,
    input  logic        id_jal,
    input  logic        id_jalr,
    input  logic [63:0] jalr_base,
    input  logic        stall_if,
    input  logic        imem_req_ready,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    output logic        flush_if_id,
    output logic        kill_resp,
    output logic        misalign,
    output logic [31:0] redirect_cnt,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_FETCH      = 2'd1,
        ST_HOLD_REDIR = 2'd2
    } state_e;

    // PC-relative target used by conditional branches and JAL (wraps mod 2^64).
    function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                  input logic [63:0] imm);
        return pc + imm;
    endfunction

    // Register-relative JALR target; bit 0 is always cleared.
    function automatic logic [63:0] jalr_target(input logic [63:0] base,
                                                input logic [63:0] imm);
        logic [63:0] sum;
        sum = base + imm;
        return {sum[63:1], 1'b0};
    endfunction

    // Sequential fetch address; wraps from the top of memory to zero silently.
    function automatic logic [63:0] seq_pc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

    state_e      state_q;
    state_e      state_d;
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [63:0] pend_pc_q;
    logic [63:0] pend_pc_d;
    logic        req_hold_q;
    logic        req_hold_d;
    logic        kill_q;
    logic        kill_d;

    logic        redirect_s;
    logic [63:0] target_s;
    logic        req_valid_s;
    logic        take_redirect_s;
    logic        flush_s;
    logic        misalign_s;
    logic        handshake_s;
    logic        req_stuck_s;

    // Decode the ID-stage control transfer and pick its target address.
    always_comb begin
        redirect_s = id_valid & (br_taken | id_jal | id_jalr);
        if (id_jalr) begin
            target_s = jalr_target(jalr_base, id_imm);
        end else begin
            target_s = branch_target(id_pc, id_imm);
        end
    end

    // FSM output decode: request valid plus the redirect side-effect pulses.
    always_comb begin
        req_valid_s     = 1'b0;
        take_redirect_s = 1'b0;
        flush_s         = 1'b0;
        misalign_s      = 1'b0;
        case (state_q)
            ST_INIT: begin
                req_valid_s = 1'b0;
            end
            ST_FETCH: begin
                // A request that was already presented stays up until accepted,
                // even if the hazard unit stalls fetch meanwhile.
                req_valid_s     = ~stall_if | req_hold_q;
                take_redirect_s = redirect_s;
                flush_s         = redirect_s;
                misalign_s      = redirect_s & target_s[1];
            end
            ST_HOLD_REDIR: begin
                // The old request must complete before the target is fetched;
                // ID activity is ignored here.
                req_valid_s = 1'b1;
            end
            default: begin
                req_valid_s = 1'b0;
            end
        endcase
    end

    assign handshake_s = req_valid_s & imem_req_ready;
    assign req_stuck_s = req_valid_s & ~imem_req_ready;

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (take_redirect_s && req_stuck_s) begin
                    state_d = ST_HOLD_REDIR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD_REDIR: begin
                if (handshake_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD_REDIR;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: fetch pc, parked target, hold flag and kill pulse.
    always_comb begin
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        req_hold_d = req_stuck_s;
        kill_d     = 1'b0;
        case (state_q)
            ST_INIT: begin
                pc_d = pc_q;
            end
            ST_FETCH: begin
                if (take_redirect_s) begin
                    if (req_stuck_s) begin
                        // Keep the unaccepted address stable; park the target.
                        pend_pc_d = target_s;
                    end else begin
                        pc_d = target_s;
                    end
                end else if (handshake_s) begin
                    pc_d = seq_pc(pc_q);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_HOLD_REDIR: begin
                if (handshake_s) begin
                    pc_d   = pend_pc_q;
                    kill_d = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_pc_q  <= 64'h0;
            req_hold_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            req_hold_q <= req_hold_d;
            kill_q     <= kill_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign flush_if_id    = flush_s;
    assign misalign       = misalign_s;
    assign kill_resp      = kill_q;

`ifdef REDIRECT_CNT_EN
    // Saturating increment for the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : (cnt + 32'd1);
    endfunction

    logic [31:0] redirect_cnt_q;
    logic [31:0] redirect_cnt_d;
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;

    // Counter next values: accepted redirects and fetch handshakes.
    always_comb begin
        if (take_redirect_s) begin
            redirect_cnt_d = sat_inc(redirect_cnt_q);
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
        if (handshake_s) begin
            fetch_cnt_d = sat_inc(fetch_cnt_q);
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= 32'h0;
            fetch_cnt_q    <= 32'h0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            fetch_cnt_q    <= fetch_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign fetch_cnt    = fetch_cnt_q;
`else
    assign redirect_cnt = 32'h0;
    assign fetch_cnt    = 32'h0;
`endif

endmodule
